router_ctrl: RTL and testbench
==============================

# router_ctrl

Connection controller for the 16x16 serial router. It watches the `frame_n`/`valid_n`/`din` lines of all input ports and shifts in each packet's 4-bit destination address. It arbitrates each output port among contending inputs with per-output round-robin, then drives the select/owner signals that steer the decode and mux datapath for the life of the packet. Packets that lose arbitration past the pad window are dropped and flagged.

## Interface
- `NPORTS`, default 16: number of input and output ports. Only 16 is supported.
- `ADDR_W`, default 4: destination address width, equal to $clog2(NPORTS).
- `clock`  in  1: single clock. All state changes on the rising edge.
- `reset_n`  in  1: reset, asynchronous and active-low.
- `din`  in  NPORTS: serial data per input. Carries the address bits during the address phase.
- `frame_n`  in  NPORTS: per-input frame, active-low. Goes high on the last payload bit.
- `valid_n`  in  NPORTS: per-input payload valid, active-low.
- `sel_vld`  out  NPORTS: input i currently owns an output.
- `sel_addr`  out  NPORTS*ADDR_W: destination of input i, in bits [4i+3:4i]. Meaningful only when `sel_vld[i]` is high.
- `out_busy_n`  out  NPORTS: output j is owned, active-low.
- `out_owner`  out  NPORTS*ADDR_W: input that owns output j, in bits [4j+3:4j].
- `drop`  out  NPORTS: one-cycle pulse when input i's packet is dropped.

## Operation
- Per-input FSM states: IDLE, ADDR, REQ, XFER, DROP.
- **IDLE → ADDR** on the edge that samples `frame_n[i]`=0. That edge also captures `din[i]` as address bit 0.
- **ADDR:** captures address bits 1..3 LSB-first, one per edge, while `frame_n[i]`=0.
  - After bit 3 the FSM goes to REQ.
  - If `frame_n[i]`=1 before bit 3, the FSM returns to IDLE with no request and no drop.
- **REQ:** raises a request to output `addr`.
  - On grant, the FSM goes to XFER.
  - If `valid_n[i]`=0 is sampled before the grant (payload started, pad window exhausted), the FSM goes to DROP and pulses `drop[i]`.
- **XFER:** `sel_vld[i]`=1 and `sel_addr[i]`=addr.
  - The FSM leaves on the edge sampling `frame_n[i]`=1 with `valid_n[i]`=0 (last bit).
  - The output is released on that same edge, and the FSM returns to IDLE.
- **DROP:** ignores data until the last bit (`frame_n[i]`=1, `valid_n[i]`=0), then goes to IDLE.
- **Per-output arbiter:**
  - Arbitrates among inputs in REQ targeting output j, only when output j is free.
  - At most one grant per output per edge.
  - Priority starts at `ptr_j` and wraps 15→0. On grant, `ptr_j` is set to the granted index + 1, modulo 16.
  - `ptr_j` resets to 0.
- **Simultaneous events:**
  - A release and a new request on the same output in the same edge: the new grant happens on the following edge. There is no same-edge reuse.
  - Two inputs finishing address capture together for the same output: the round-robin winner is granted, and the loser stays in REQ.
- Different outputs are fully independent.

## Timing
- **Reset values:** all FSMs IDLE; `sel_vld`=0; `sel_addr`=0; `out_busy_n`=all 1; `out_owner`=0; `drop`=0; all `ptr`=0.
- **Reset mid-packet:** all connections are torn down immediately. Inputs must restart at a new frame.
- **Address phase:** edges e0..e3 sample address bits. REQ holds during the cycle after e3.
- **Grant timing:** an uncontended grant registers at e4. `sel_vld`, `out_busy_n` and `out_owner` are valid in the cycle after e4.
  - The protocol's 5 pad cycles, with `valid_n` high, allow up to 4 cycles of contention wait.
- **Release timing:** at the last-bit edge, `sel_vld[i]`→0 and `out_busy_n[j]`→1 in the following cycle.
- **Drop pulse:** `drop[i]` is high for exactly one cycle, the cycle after the offending edge.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- **Shared package `router_pkg`:** `NPORTS`, `ADDR_W`, and the `in_state_t` enum {IDLE, ADDR, REQ, XFER, DROP}. The package is shared with the decode/mux datapath.
- **Sub-module `rr_arbiter_16`:** 16-bit request vector, registered pointer, one-hot grant, and a grant-valid flag. It is instantiated once per output.
- The per-input FSMs are a generate loop inside `router_ctrl`.

## Test plan
- **Single packet:** input 3 sends address 0xA (bits 0,1,0,1) then payload → `sel_vld[3]`=1 and `out_owner[A]`=3 one cycle after e4. `out_busy_n[A]` is released the cycle after the last bit.
- **Contention:** inputs 2 and 7 both target output 5 starting at the same cycle, with `ptr`=0 → input 2 is granted at e4. Input 7 is granted the cycle after input 2 releases, provided input 7 is still in pad; otherwise `drop[7]` pulses.
- **Round-robin fairness:** inputs 0, 1 and 15 repeatedly target output 9 → over three rounds, grants are 0, 1, 15, 0 … (pointer wrap checked).
- **Early abort:** `frame_n[4]` rises after 2 address bits → input 4 returns to IDLE, no request, no drop.
- **Pad exhausted:** output 6 is held long by input 1, and input 8 targeting output 6 sees `valid_n[8]`=0 while in REQ → `drop[8]` pulses for one cycle. Input 8 ignores the packet and re-arms on the next frame.
- **Reset mid-transfer:** `reset_n` is pulled low with 3 connections active → all outputs return to reset values immediately, with no dependency on the clock.

Source files
------------

// File: rtl/router_pkg.sv
// Shared definitions for the 16x16 serial router control and datapath.
package router_pkg;

  localparam int NPORTS = 16;
  localparam int ADDR_W = $clog2(NPORTS);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    REQ,
    XFER,
    DROP
  } in_state_t;

endpackage

// File: rtl/rr_arbiter_16.sv
// Round-robin arbiter for one output: the search starts at the registered pointer,
// and the pointer moves to one past the winner whenever a grant is issued.
module rr_arbiter_16
  import router_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              en,
  input  logic [NPORTS-1:0] req,
  output logic [NPORTS-1:0] gnt,
  output logic              gnt_vld,
  output logic [ADDR_W-1:0] gnt_idx
);

  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] idx;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can leave a latch behind.
    gnt     = '0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    if (en) begin
      for (int k = 0; k < NPORTS; k++) begin
        idx = ptr + ADDR_W'(k);
        if (!gnt_vld && req[idx]) begin
          gnt_vld  = 1'b1;
          gnt_idx  = idx;
          gnt[idx] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!reset_n) begin
      ptr <= '0;
    end else if (gnt_vld) begin
      ptr <= gnt_idx + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/router_ctrl.sv
// Connection controller: per-input address capture FSMs, per-output round-robin
// arbitration, and the registered select/owner outputs that steer the datapath.
module router_ctrl
  import router_pkg::*;
#(
  parameter int NPORTS = router_pkg::NPORTS,
  parameter int ADDR_W = router_pkg::ADDR_W
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [NPORTS-1:0]        din,
  input  logic [NPORTS-1:0]        frame_n,
  input  logic [NPORTS-1:0]        valid_n,
  output logic [NPORTS-1:0]        sel_vld,
  output logic [NPORTS*ADDR_W-1:0] sel_addr,
  output logic [NPORTS-1:0]        out_busy_n,
  output logic [NPORTS*ADDR_W-1:0] out_owner,
  output logic [NPORTS-1:0]        drop
);

  in_state_t         state_vec [NPORTS];
  logic [ADDR_W-1:0] addr_vec  [NPORTS];
  logic [ADDR_W-1:0] sel_vec   [NPORTS];

  logic [NPORTS-1:0][NPORTS-1:0] req;
  logic [NPORTS-1:0][NPORTS-1:0] gnt;
  logic [NPORTS-1:0]             gnt_vld;
  logic [NPORTS-1:0][ADDR_W-1:0] gnt_idx;
  logic [NPORTS-1:0]             in_gnt;
  logic [NPORTS-1:0]             rel;
  logic [NPORTS-1:0]             busy_n_q;
  logic [NPORTS-1:0][ADDR_W-1:0] owner_q;

  always_comb begin
    req = '0;
    for (int i = 0; i < NPORTS; i++) begin
      if (state_vec[i] == REQ) req[addr_vec[i]][i] = 1'b1;
    end
  end

  always_comb begin
    in_gnt = '0;
    for (int j = 0; j < NPORTS; j++) in_gnt = in_gnt | gnt[j];
  end

  // An owner sampling its last bit frees its output; the arbiter only sees it free next edge.
  always_comb begin
    rel = '0;
    for (int i = 0; i < NPORTS; i++) begin
      if (sel_vld[i] && frame_n[i] && !valid_n[i]) rel[sel_vec[i]] = 1'b1;
    end
  end

  for (genvar j = 0; j < NPORTS; j++) begin : g_arb
    rr_arbiter_16 u_arb (
      .clock   (clock),
      .reset_n (reset_n),
      .en      (busy_n_q[j]),
      .req     (req[j]),
      .gnt     (gnt[j]),
      .gnt_vld (gnt_vld[j]),
      .gnt_idx (gnt_idx[j])
    );
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy_n_q <= '1;
      owner_q  <= '0;
    end else begin
      for (int j = 0; j < NPORTS; j++) begin
        if (gnt_vld[j]) begin
          busy_n_q[j] <= 1'b0;
          owner_q[j]  <= gnt_idx[j];
        end else if (rel[j]) begin
          busy_n_q[j] <= 1'b1;
        end
      end
    end
  end

  assign out_busy_n = busy_n_q;
  assign out_owner  = owner_q;

  for (genvar i = 0; i < NPORTS; i++) begin : g_in
    in_state_t         state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] sel;
    logic [1:0]        cnt;
    logic              vld;
    logic              drp;

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        state <= IDLE;
        addr  <= '0;
        sel   <= '0;
        cnt   <= '0;
        vld   <= 1'b0;
        drp   <= 1'b0;
      end else begin
        drp <= 1'b0;
        unique case (state)
          IDLE: begin
            if (!frame_n[i]) begin
              addr[0] <= din[i];
              cnt     <= 2'd1;
              state   <= ADDR;
            end
          end
          ADDR: begin
            if (frame_n[i]) begin
              state <= IDLE;
            end else begin
              addr[cnt] <= din[i];
              if (cnt == 2'd3) state <= REQ;
              else             cnt   <= cnt + 2'd1;
            end
          end
          REQ: begin
            // A grant on the same edge as the first payload bit still wins.
            if (in_gnt[i]) begin
              state <= XFER;
              vld   <= 1'b1;
              sel   <= addr;
            end else if (!valid_n[i]) begin
              drp   <= 1'b1;
              state <= frame_n[i] ? IDLE : DROP;
            end
          end
          XFER: begin
            if (frame_n[i] && !valid_n[i]) begin
              state <= IDLE;
              vld   <= 1'b0;
            end
          end
          DROP: begin
            if (frame_n[i] && !valid_n[i]) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end

    assign state_vec[i] = state;
    assign addr_vec[i]  = addr;
    assign sel_vec[i]   = sel;
    assign sel_vld[i]   = vld;
    assign drop[i]      = drp;
    assign sel_addr[i*ADDR_W +: ADDR_W] = sel;
  end

endmodule

// File: tb/tb_router_ctrl.sv
// Bench for router_ctrl: directed and random packet streams per input, checked each
// cycle against a connection-level reference model of owners, waiters and pointers.
module tb_router_ctrl;

  localparam int N  = 16;
  localparam int QD = 1024;

  logic          clock;
  logic          reset_n;
  logic [N-1:0]  din;
  logic [N-1:0]  frame_n;
  logic [N-1:0]  valid_n;
  logic [N-1:0]  sel_vld;
  logic [N*4-1:0] sel_addr;
  logic [N-1:0]  out_busy_n;
  logic [N*4-1:0] out_owner;
  logic [N-1:0]  drop;

  router_ctrl dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .din        (din),
    .frame_n    (frame_n),
    .valid_n    (valid_n),
    .sel_vld    (sel_vld),
    .sel_addr   (sel_addr),
    .out_busy_n (out_busy_n),
    .out_owner  (out_owner),
    .drop       (drop)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Per-input stimulus waveforms, one {frame_n, valid_n, din} entry per cycle.
  logic [2:0] wave [N][QD];
  int wr [N];
  int rd [N];

  // Reference model: which output each input holds, who waits where, and pointers.
  int own_out  [N];
  bit wait_req [N];
  int dest     [N];
  int nbits    [N];
  bit dropping [N];
  bit drop_exp [N];
  int owner    [N];
  int ptr      [N];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      own_out[i] = -1; wait_req[i] = 0; dest[i] = 0; nbits[i] = 0;
      dropping[i] = 0; drop_exp[i] = 0; owner[i] = -1; ptr[i] = 0;
    end
  endtask

  task automatic model_edge();
    int win [N];
    for (int j = 0; j < N; j++) begin
      win[j] = -1;
      if (owner[j] < 0) begin
        for (int k = 0; k < N; k++) begin
          int c = (ptr[j] + k) % N;
          if (win[j] < 0 && wait_req[c] && dest[c] == j) win[j] = c;
        end
      end
      if (win[j] >= 0) ptr[j] = (win[j] + 1) % N;
    end
    for (int i = 0; i < N; i++) begin
      bit last = frame_n[i] && !valid_n[i];
      drop_exp[i] = 0;
      if (own_out[i] >= 0) begin
        if (last) begin
          owner[own_out[i]] = -1;
          own_out[i] = -1;
        end
      end else if (wait_req[i]) begin
        if (win[dest[i]] == i) begin
          own_out[i] = dest[i];
          owner[dest[i]] = i;
          wait_req[i] = 0;
        end else if (!valid_n[i]) begin
          drop_exp[i] = 1;
          wait_req[i] = 0;
          dropping[i] = !frame_n[i];
        end
      end else if (dropping[i]) begin
        if (last) dropping[i] = 0;
      end else if (nbits[i] > 0) begin
        if (frame_n[i]) nbits[i] = 0;
        else begin
          dest[i] = dest[i] | (int'(din[i]) << nbits[i]);
          nbits[i]++;
          if (nbits[i] == 4) begin
            nbits[i] = 0;
            wait_req[i] = 1;
          end
        end
      end else if (!frame_n[i]) begin
        dest[i]  = int'(din[i]);
        nbits[i] = 1;
      end
    end
  endtask

  task automatic compare();
    logic [N-1:0]   e_vld, e_busy, e_drop;
    logic [N*4-1:0] e_addr, m_addr, e_own, m_own;
    e_vld = '0; e_busy = '0; e_drop = '0;
    e_addr = '0; m_addr = '0; e_own = '0; m_own = '0;
    for (int i = 0; i < N; i++) begin
      e_drop[i] = drop_exp[i];
      if (own_out[i] >= 0) begin
        e_vld[i] = 1'b1;
        m_addr[i*4 +: 4] = 4'hF;
        e_addr[i*4 +: 4] = 4'(own_out[i]);
      end
      e_busy[i] = (owner[i] < 0);
      if (owner[i] >= 0) begin
        m_own[i*4 +: 4] = 4'hF;
        e_own[i*4 +: 4] = 4'(owner[i]);
      end
    end
    check("sel_vld",    64'(sel_vld),             64'(e_vld));
    check("sel_addr",   64'(sel_addr & m_addr),   64'(e_addr));
    check("out_busy_n", 64'(out_busy_n),          64'(e_busy));
    check("out_owner",  64'(out_owner & m_own),   64'(e_own));
    check("drop",       64'(drop),                64'(e_drop));
  endtask

  task automatic push(input int i, input logic [2:0] e);
    wave[i][wr[i] % QD] = e;
    wr[i]++;
  endtask

  task automatic add_pkt(input int i, input int dst, input int pad, input int len, input int gap);
    logic [3:0] a;
    a = 4'(dst);
    for (int g = 0; g < gap; g++) push(i, 3'b110);
    for (int b = 0; b < 4; b++)   push(i, {2'b01, a[b]});
    for (int p = 0; p < pad; p++) push(i, 3'b010);
    for (int l = 0; l < len; l++) push(i, {(l == len - 1), 1'b0, 1'($urandom_range(0, 1))});
    push(i, 3'b110);
  endtask

  task automatic add_abort(input int i, input int nb);
    for (int b = 0; b < nb; b++) push(i, {2'b01, 1'($urandom_range(0, 1))});
    push(i, 3'b110);
  endtask

  task automatic step();
    logic [2:0] e;
    for (int i = 0; i < N; i++) begin
      if (rd[i] != wr[i]) begin
        e = wave[i][rd[i] % QD];
        rd[i]++;
      end else begin
        e = 3'b110;
      end
      frame_n[i] = e[2];
      valid_n[i] = e[1];
      din[i]     = e[0];
    end
    @(posedge clock);
    model_edge();
    @(negedge clock);
    compare();
  endtask

  function automatic bit quiet();
    bit q = 1;
    for (int i = 0; i < N; i++) begin
      if (rd[i] != wr[i] || own_out[i] >= 0 || wait_req[i] || dropping[i] || nbits[i] != 0) q = 0;
    end
    return q;
  endfunction

  task automatic drain(input int limit);
    int n = 0;
    while (!quiet() && n < limit) begin
      step();
      n++;
    end
    check("drain_done", 64'(quiet()), 64'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_sel_vld"},  64'(sel_vld),    64'd0);
    check({tag, "_sel_addr"}, 64'(sel_addr),   64'd0);
    check({tag, "_busy_n"},   64'(out_busy_n), 64'hFFFF);
    check({tag, "_owner"},    64'(out_owner),  64'd0);
    check({tag, "_drop"},     64'(drop),       64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    frame_n = '1;
    valid_n = '1;
    din     = '0;
    for (int i = 0; i < N; i++) begin wr[i] = 0; rd[i] = 0; end
    model_reset();
    @(negedge clock);
    check_reset_values("rst");
    @(negedge clock);
    reset_n = 1'b1;

    // Single packet: input 3 to output 0xA.
    add_pkt(3, 4'hA, 5, 8, 1);
    drain(100);

    // Contention on output 5: input 7 survives with a long pad, then drops with a short one.
    add_pkt(2, 5, 5, 3, 0);
    add_pkt(7, 5, 12, 3, 0);
    drain(100);
    add_pkt(2, 5, 5, 3, 0);
    add_pkt(7, 5, 5, 3, 0);
    drain(100);

    // Round-robin on output 9 across inputs 0, 1, 15 with pointer wrap.
    for (int r = 0; r < 3; r++) begin
      add_pkt(0, 9, 30, 4, 0);
      add_pkt(1, 9, 30, 4, 0);
      add_pkt(15, 9, 30, 4, 0);
      drain(200);
    end

    // Early abort after two address bits.
    add_abort(4, 2);
    drain(20);

    // Pad exhausted on output 6, then input 8 re-arms on a fresh frame.
    add_pkt(1, 6, 5, 20, 0);
    add_pkt(8, 6, 2, 4, 2);
    drain(100);
    add_pkt(8, 6, 3, 4, 0);
    drain(100);

    // Asynchronous reset with three live connections.
    add_pkt(5, 1, 2, 60, 0);
    add_pkt(6, 2, 2, 60, 0);
    add_pkt(9, 3, 2, 60, 0);
    for (int c = 0; c < 12; c++) step();
    check("pre_rst_vld", 64'(sel_vld), 64'h0260);
    #3;
    reset_n = 1'b0;
    #1;
    check_reset_values("arst");
    model_reset();
    for (int i = 0; i < N; i++) rd[i] = wr[i];
    frame_n = '1;
    valid_n = '1;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    add_pkt(5, 1, 2, 3, 0);
    drain(50);

    // Random traffic biased onto a few outputs for contention.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (rd[i] == wr[i] && $urandom_range(0, 5) == 0) begin
          if ($urandom_range(0, 9) == 0) begin
            add_abort(i, $urandom_range(1, 3));
          end else begin
            int dst;
            dst = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 2);
            add_pkt(i, dst, $urandom_range(0, 10), $urandom_range(1, 12), $urandom_range(0, 3));
          end
        end
      end
      step();
    end
    drain(500);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
